tilt_to_move: RTL and testbench

//  Converts raw signed accelerometer X/Y samples into the one-hot movement[3:0] word and update tick that drive the ball stage.

---
 rtl/labyrinth_pkg.sv | 15 +
 rtl/tilt_to_move_if.sv | 25 ++
 rtl/tick_gen.sv | 33 +++
 rtl/tilt_to_move.sv | 154 +++++++++++++++
 tb/tb_tilt_to_move.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/labyrinth_pkg.sv
// Shared definitions for the labyrinth ball pipeline: one-hot movement
// directions consumed by the ball stage and the tilt calibration states.
package labyrinth_pkg;

  localparam logic [3:0] UP    = 4'b0001;
  localparam logic [3:0] DOWN  = 4'b0010;
  localparam logic [3:0] LEFT  = 4'b0100;
  localparam logic [3:0] RIGHT = 4'b1000;

  typedef enum logic {
    RUN = 1'b0,
    CAL = 1'b1
  } cal_state_t;

endpackage

// File: rtl/tilt_to_move_if.sv
// Accelerometer sample stream in, movement word and update tick out.
// The master is the upstream sample source; the slave is tilt_to_move.
interface tilt_to_move_if #(
  parameter int SAMPLE_W = 8
);

  logic signed [SAMPLE_W-1:0] accel_x;
  logic signed [SAMPLE_W-1:0] accel_y;
  logic                       accel_valid;
  logic                       cal_req;
  logic [3:0]                 movement;
  logic                       update;
  logic                       calibrating;

  modport master (
    output accel_x, accel_y, accel_valid, cal_req,
    input  movement, update, calibrating
  );

  modport slave (
    input  accel_x, accel_y, accel_valid, cal_req,
    output movement, update, calibrating
  );

endinterface

// File: rtl/tick_gen.sv
// Rate divider: free-running 0..PERIOD-1 counter, update high for the
// single cycle in which the counter wraps.
module tick_gen #(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int UPDATE_FREQUENCY_HZ    = 30,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic clk,
  input  logic reset,
  output logic update
);

  localparam int PERIOD = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                          : CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ;
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign update = (cnt_reg == LAST);

endmodule

// File: rtl/tilt_to_move.sv
// Tilt to movement: windowed averaging, offset calibration, dead zone with
// hysteresis and dominant-axis selection into a tick-aligned one-hot word.
module tilt_to_move
  import labyrinth_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int UPDATE_FREQUENCY_HZ    = 30,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5,
  parameter int SAMPLE_W               = 8,
  parameter int AVG_LOG2               = 2,
  parameter int DEAD_ZONE              = 20,
  parameter int HYST                   = 4
) (
  input  logic          clk,
  input  logic          reset,
  tilt_to_move_if.slave bus
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int MAG_W = SAMPLE_W - 1;
  localparam logic signed [SAMPLE_W-1:0] FILT_MAX = {1'b0, {MAG_W{1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] FILT_MIN = -FILT_MAX;
  localparam logic signed [SAMPLE_W:0]   SAT_HI   = (SAMPLE_W+1)'(2**MAG_W - 1);
  localparam logic signed [SAMPLE_W:0]   SAT_LO   = -SAT_HI;
  localparam logic [MAG_W-1:0] ON_LEVEL  = MAG_W'(DEAD_ZONE);
  localparam logic [MAG_W-1:0] OFF_LEVEL = MAG_W'(DEAD_ZONE - HYST);

  // Symmetric clamp keeps |filt| representable in MAG_W bits.
  function automatic logic signed [SAMPLE_W-1:0] sat_sub(
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [SAMPLE_W-1:0] b
  );
    logic signed [SAMPLE_W:0] d;
    d = {a[SAMPLE_W-1], a} - {b[SAMPLE_W-1], b};
    if (d > SAT_HI)      return FILT_MAX;
    else if (d < SAT_LO) return FILT_MIN;
    else                 return d[SAMPLE_W-1:0];
  endfunction

  function automatic logic [MAG_W-1:0] mag_of(input logic signed [SAMPLE_W-1:0] f);
    return f[SAMPLE_W-1] ? -f[MAG_W-1:0] : f[MAG_W-1:0];
  endfunction

  function automatic logic hyst_next(input logic act, input logic [MAG_W-1:0] m);
    if (!act) return m > ON_LEVEL;
    else      return !(m < OFF_LEVEL);
  endfunction

  logic [AVG_LOG2-1:0]        win_cnt_reg;
  logic                       win_done;
  cal_state_t                 state_reg, state_next;
  logic signed [SAMPLE_W-1:0] sample [2];
  logic signed [SAMPLE_W-1:0] filt [2];
  logic [MAG_W-1:0]           mag [2];
  logic                       active [2];
  logic                       upd_d_reg;
  logic                       update;
  logic [3:0]                 movement_reg;
  logic [3:0]                 dir;
  logic                       sel_x, sel_y;

  assign sample[0] = bus.accel_x;
  assign sample[1] = bus.accel_y;
  assign win_done  = bus.accel_valid && (win_cnt_reg == '1);

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic signed [ACC_W-1:0]    acc_reg, sum;
    logic signed [SAMPLE_W-1:0] avg, offset_reg, filt_reg, filt_new;
    logic                       active_reg;

    assign sum      = acc_reg + {{AVG_LOG2{sample[gi][SAMPLE_W-1]}}, sample[gi]};
    assign avg      = sum[ACC_W-1:AVG_LOG2];
    assign filt_new = sat_sub(avg, offset_reg);

    // The closing sample goes into sum, so clearing acc on completion loses nothing.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc_reg    <= '0;
        offset_reg <= '0;
        filt_reg   <= '0;
        active_reg <= 1'b0;
      end else if (bus.accel_valid) begin
        acc_reg <= win_done ? '0 : sum;
        if (win_done) begin
          if (state_reg == CAL) begin
            offset_reg <= avg;
            filt_reg   <= '0;
          end else begin
            filt_reg   <= filt_new;
            active_reg <= hyst_next(active_reg, mag_of(filt_new));
          end
        end
      end
    end

    assign filt[gi]   = filt_reg;
    assign mag[gi]    = mag_of(filt_reg);
    assign active[gi] = active_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (bus.cal_req) state_next = CAL;
      CAL:     if (win_done)    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    sel_x = active[0] && (!active[1] || (mag[0] >= mag[1]));
    sel_y = active[1] && !sel_x;
    dir   = '0;
    if (sel_x) begin
      if (filt[0][SAMPLE_W-1])  dir = LEFT;
      else if (filt[0] != '0)   dir = RIGHT;
    end else if (sel_y) begin
      if (filt[1][SAMPLE_W-1])  dir = UP;
      else if (filt[1] != '0)   dir = DOWN;
    end
  end

  // Load one cycle after the tick so a window closing on the tick edge is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt_reg  <= '0;
      state_reg    <= RUN;
      upd_d_reg    <= 1'b0;
      movement_reg <= '0;
    end else begin
      if (bus.accel_valid) win_cnt_reg <= win_cnt_reg + AVG_LOG2'(1);
      state_reg <= state_next;
      upd_d_reg <= update;
      if (upd_d_reg) movement_reg <= (state_reg == CAL) ? 4'b0000 : dir;
    end
  end

  tick_gen #(
    .CLK_FREQUENCY_HZ      (CLK_FREQUENCY_HZ),
    .UPDATE_FREQUENCY_HZ   (UPDATE_FREQUENCY_HZ),
    .SIMULATE              (SIMULATE),
    .SIMULATE_FREQUENCY_CNT(SIMULATE_FREQUENCY_CNT)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .update(update)
  );

  assign bus.update      = update;
  assign bus.movement    = movement_reg;
  assign bus.calibrating = (state_reg == CAL);

endmodule

// File: tb/tb_tilt_to_move.sv
// Bench for tilt_to_move: windows of identical samples, expected movement
// queued per window and compared after the following tick has loaded it.
module tb_tilt_to_move;
  import labyrinth_pkg::*;

  localparam int SAMPLE_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tilt_to_move_if #(.SAMPLE_W(SAMPLE_W)) bus ();

  tilt_to_move #(
    .SIMULATE              (1),
    .SIMULATE_FREQUENCY_CNT(5),
    .SAMPLE_W              (SAMPLE_W),
    .AVG_LOG2              (2),
    .DEAD_ZONE             (20),
    .HYST                  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_window(input int x, input int y, input logic [3:0] exp);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.accel_x     = SAMPLE_W'(x);
      bus.accel_y     = SAMPLE_W'(y);
      bus.accel_valid = 1'b1;
      @(negedge clk);
      bus.accel_valid = 1'b0;
    end
    exp_q.push_back(exp);
    $display("window x=%0d y=%0d expect movement=%b", x, y, exp);
  endtask

  // Wait for the next tick, then for the load cycle after it.
  task automatic expect_tick(input string tag);
    int waited = 0;
    logic [3:0] exp;
    exp = exp_q.pop_front();
    while (bus.update !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_val({tag, "_tick"}, 32'(bus.update), 32'd1);
    if (bus.update === 1'b1) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      check_val(tag, 32'(bus.movement), 32'(exp));
      $display("tick %s movement=%b", tag, bus.movement);
    end
  endtask

  task automatic pulse_cal(input string tag);
    @(negedge clk);
    bus.cal_req = 1'b1;
    @(negedge clk);
    bus.cal_req = 1'b0;
    check_val({tag, "_cal_high"}, 32'(bus.calibrating), 32'd1);
  endtask

  initial begin
    bus.accel_x     = '0;
    bus.accel_y     = '0;
    bus.accel_valid = 1'b0;
    bus.cal_req     = 1'b0;

    // Strobes under reset must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.accel_x     = SAMPLE_W'(40);
      bus.accel_valid = 1'b1;
    end
    @(negedge clk);
    bus.accel_valid = 1'b0;
    check_val("rst_movement", 32'(bus.movement), 32'd0);
    check_val("rst_calibrating", 32'(bus.calibrating), 32'd0);
    check_val("rst_update", 32'(bus.update), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check_val($sformatf("first_tick_cycle%0d", i), 32'(bus.update), 32'(i == 5));
    end

    drive_window(40, 0, RIGHT);   expect_tick("right");
    drive_window(-40, 0, LEFT);   expect_tick("left");
    drive_window(0, -40, UP);     expect_tick("up");
    drive_window(22, 0, RIGHT);   expect_tick("hyst_on22");
    drive_window(17, 0, RIGHT);   expect_tick("hyst_hold17");
    drive_window(15, 0, 4'b0000); expect_tick("hyst_off15");
    drive_window(30, -30, RIGHT); expect_tick("tie_x");
    drive_window(30, 31, DOWN);   expect_tick("y_larger");

    pulse_cal("cal50");
    drive_window(50, 0, 4'b0000);
    check_val("cal50_cal_low", 32'(bus.calibrating), 32'd0);
    expect_tick("cal50_zero");
    drive_window(50, 0, 4'b0000); expect_tick("offset_zero");
    drive_window(75, 0, RIGHT);   expect_tick("offset_right");

    pulse_cal("calm100");
    drive_window(-100, 0, 4'b0000);
    check_val("calm100_cal_low", 32'(bus.calibrating), 32'd0);
    expect_tick("calm100_zero");
    drive_window(127, 0, RIGHT);  expect_tick("sat_pos");
    drive_window(0, -128, UP);    expect_tick("sat_neg");

    // Partial window, then asynchronous reset between clock edges.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.accel_x     = SAMPLE_W'(100);
      bus.accel_y     = '0;
      bus.accel_valid = 1'b1;
      @(negedge clk);
      bus.accel_valid = 1'b0;
    end
    check_val("pre_reset_movement", 32'(bus.movement), 32'(UP));
    #2 reset = 1'b0;
    #1;
    check_val("async_movement", 32'(bus.movement), 32'd0);
    check_val("async_calibrating", 32'(bus.calibrating), 32'd0);
    check_val("async_update", 32'(bus.update), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive_window(-40, 0, LEFT);   expect_tick("post_reset_left");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
